// File: rtl/id_stage.sv
// Instruction-decode stage sitting in front of the 32x32 register file.
// Decodes the fetched word, drives register file read addresses, bypasses a
// same-cycle writeback, detects load-use hazards and owns the ID/EX register.
module id_stage #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [AW-1:0]   ra1,
    output logic [AW-1:0]   ra2,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_wa,
    input  logic [XLEN-1:0] wb_wd,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_op_a,
    output logic [XLEN-1:0] ex_op_b,
    output logic [XLEN-1:0] ex_imm,
    output logic [5:0]      ex_opcode,
    output logic [5:0]      ex_funct,
    output logic [AW-1:0]   ex_rd,
    output logic            ex_we,
    output logic            ex_is_load
);

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [AW-1:0]   rs;
    logic [AW-1:0]   rt;
    logic [AW-1:0]   dest;
    logic            uses_rt;
    logic            dec_we;
    logic            dec_load;
    logic [AW-1:0]   dec_rd;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            hz;
    logic            adv;
    logic            load_payload;

    assign opcode = if_instr[31:26];
    assign funct  = if_instr[5:0];
    assign rs     = if_instr[25:21];
    assign rt     = if_instr[20:16];
    assign ra1    = rs;
    assign ra2    = rt;

    // Instruction class decode: destination, rt usage, write enable, load flag.
    always_comb begin
        dest     = rt;
        uses_rt  = 1'b0;
        dec_we   = 1'b1;
        dec_load = 1'b0;
        case (opcode)
            6'h00: begin
                dest    = if_instr[15:11];
                uses_rt = 1'b1;
            end
            6'h23: dec_load = 1'b1;
            6'h2B, 6'h04, 6'h05: begin
                dec_we  = 1'b0;
                uses_rt = 1'b1;
            end
            default: ;
        endcase
        if (dest == '0) begin
            dec_we = 1'b0;
        end
        dec_rd = dec_we ? dest : '0;
    end

    // Logical immediates are zero-extended, everything else sign-extended.
    always_comb begin
        case (opcode)
            6'h0C, 6'h0D, 6'h0E: dec_imm = {{(XLEN-16){1'b0}}, if_instr[15:0]};
            default:             dec_imm = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
        endcase
    end

    // Operand select: r0 reads zero, a same-cycle writeback wins over stale file data.
    always_comb begin
        if (rs == '0) begin
            op_a = '0;
        end else if (wb_we && (wb_wa == rs)) begin
            op_a = wb_wd;
        end else begin
            op_a = rd1;
        end
        if (rt == '0) begin
            op_b = '0;
        end else if (wb_we && (wb_wa == rt)) begin
            op_b = wb_wd;
        end else begin
            op_b = rd2;
        end
    end

    // Load-use hazard against the load currently held in ID/EX.
    always_comb begin
        hz = ex_valid && ex_is_load && ex_we && (ex_rd != '0) &&
             ((ex_rd == rs) || (uses_rt && (ex_rd == rt)));
    end

    assign adv          = !ex_valid || ex_ready;
    assign if_ready     = adv && !hz;
    assign load_payload = adv && if_valid && !hz;

    // ID/EX valid bit: advances whenever EX can take a new entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
        end else if (adv) begin
            ex_valid <= if_valid && !hz;
        end
    end

    // ID/EX payload: only overwritten by an accepted instruction, otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_pc      <= '0;
            ex_op_a    <= '0;
            ex_op_b    <= '0;
            ex_imm     <= '0;
            ex_opcode  <= '0;
            ex_funct   <= '0;
            ex_rd      <= '0;
            ex_we      <= 1'b0;
            ex_is_load <= 1'b0;
        end else if (load_payload) begin
            ex_pc      <= if_pc;
            ex_op_a    <= op_a;
            ex_op_b    <= op_b;
            ex_imm     <= dec_imm;
            ex_opcode  <= opcode;
            ex_funct   <= funct;
            ex_rd      <= dec_rd;
            ex_we      <= dec_we;
            ex_is_load <= dec_load;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus a randomized run
// checked against a rule-level model of the decode stage.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;
    logic [31:0] ex_imm;
    logic [5:0]  ex_opcode;
    logic [5:0]  ex_funct;
    logic [4:0]  ex_rd;
    logic        ex_we;
    logic        ex_is_load;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rd;
        logic        we;
        logic        load;
    } ex_t;

    ex_t model;

    id_stage #(.XLEN(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
        .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_rd(ex_rd),
        .ex_we(ex_we), .ex_is_load(ex_is_load)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // What an accepted instruction should look like once it sits in EX.
    function automatic ex_t model_accept(input logic [31:0] instr, input logic [31:0] pc,
                                         input logic [31:0] r1, input logic [31:0] r2,
                                         input logic wwe, input logic [4:0] wwa,
                                         input logic [31:0] wwd);
        ex_t e;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
        logic       writes;
        op = instr[31:26];
        rs = instr[25:21];
        rt = instr[20:16];
        e.valid  = 1'b1;
        e.pc     = pc;
        e.opcode = op;
        e.funct  = instr[5:0];
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) e.imm = {16'h0000, instr[15:0]};
        else e.imm = 32'(signed'(instr[15:0]));
        e.a = (rs == 0) ? 32'd0 : ((wwe && wwa == rs) ? wwd : r1);
        e.b = (rt == 0) ? 32'd0 : ((wwe && wwa == rt) ? wwd : r2);
        dest   = (op == 6'h00) ? instr[15:11] : rt;
        writes = !(op == 6'h2B || op == 6'h04 || op == 6'h05) && dest != 0;
        e.we   = writes;
        e.rd   = writes ? dest : 5'd0;
        e.load = (op == 6'h23);
        return e;
    endfunction

    // A stall happens when the held load writes a register the new instruction reads.
    function automatic logic model_stall(input ex_t m, input logic [31:0] instr);
        logic [5:0] op;
        logic       reads_rt;
        op = instr[31:26];
        reads_rt = (op == 6'h00 || op == 6'h2B || op == 6'h04 || op == 6'h05);
        return m.valid && m.load && m.we && m.rd != 0 &&
               (m.rd == instr[25:21] || (reads_rt && m.rd == instr[20:16]));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
        rd1 = 32'd0; rd2 = 32'd0;
        wb_we = 1'b0; wb_wa = 5'd0; wb_wd = 32'd0;
        ex_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model = '0;
        #1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        idle_inputs();
        rst_n = 1'b1;
        #3;
        rst_n = 1'b0;
        if_valid = 1'b1;
        #1;
        checks++;
        if ({ex_valid, ex_pc, ex_op_a, ex_op_b, ex_imm, ex_opcode, ex_funct, ex_rd, ex_we, ex_is_load} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state got valid=%b pc=%h a=%h want all zero", ex_valid, ex_pc, ex_op_a);
        end
        checks++;
        if (if_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_if_ready got %b want 1", if_ready);
        end
        if_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_bypass();
        $display("[TB] test_bypass");
        do_reset();
        if_valid = 1'b1; if_pc = 32'h40;
        if_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        rd1 = 32'd5; rd2 = 32'h77;
        wb_we = 1'b1; wb_wa = 5'd1; wb_wd = 32'hAA;
        #1;
        checks++;
        if ({if_ready, ra1, ra2} !== {1'b1, 5'd1, 5'd2}) begin
            errors++;
            $display("[TB] FAIL read_addr got rdy=%b ra1=%0d ra2=%0d want 1 1 2", if_ready, ra1, ra2);
        end
        tick();
        checks++;
        if ({ex_valid, ex_op_a, ex_op_b, ex_rd, ex_we} !== {1'b1, 32'hAA, 32'h77, 5'd3, 1'b1}) begin
            errors++;
            $display("[TB] FAIL bypass_rs got v=%b a=%h b=%h rd=%0d we=%b want 1 aa 77 3 1",
                     ex_valid, ex_op_a, ex_op_b, ex_rd, ex_we);
        end
        if_instr = rtype(5'd0, 5'd2, 5'd3, 6'h20);
        wb_wa = 5'd0; wb_wd = 32'hBB;
        tick();
        checks++;
        if ({ex_op_a, ex_op_b} !== {32'd0, 32'h77}) begin
            errors++;
            $display("[TB] FAIL bypass_r0 got a=%h b=%h want 0 77", ex_op_a, ex_op_b);
        end
        if_instr = rtype(5'd6, 5'd2, 5'd3, 6'h20);
        wb_wa = 5'd2; wb_wd = 32'hCC;
        tick();
        checks++;
        if ({ex_op_a, ex_op_b} !== {32'd5, 32'hCC}) begin
            errors++;
            $display("[TB] FAIL bypass_rt got a=%h b=%h want 5 cc", ex_op_a, ex_op_b);
        end
        idle_inputs();
    endtask

    task automatic test_load_use();
        $display("[TB] test_load_use");
        do_reset();
        if_valid = 1'b1; if_pc = 32'h100;
        if_instr = itype(6'h23, 5'd1, 5'd4, 16'd8);
        tick();
        checks++;
        if ({ex_valid, ex_is_load, ex_rd, ex_we} !== {1'b1, 1'b1, 5'd4, 1'b1}) begin
            errors++;
            $display("[TB] FAIL lw_accept got v=%b ld=%b rd=%0d we=%b want 1 1 4 1",
                     ex_valid, ex_is_load, ex_rd, ex_we);
        end
        if_pc = 32'h104;
        if_instr = rtype(5'd4, 5'd2, 5'd5, 6'h20);
        #1;
        checks++;
        if (if_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_ready got %b want 0", if_ready);
        end
        tick();
        checks++;
        if ({ex_valid, if_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL bubble got v=%b rdy=%b want 0 1", ex_valid, if_ready);
        end
        tick();
        checks++;
        if ({ex_valid, ex_pc, ex_rd} !== {1'b1, 32'h104, 5'd5}) begin
            errors++;
            $display("[TB] FAIL after_bubble got v=%b pc=%h rd=%0d want 1 104 5", ex_valid, ex_pc, ex_rd);
        end
        idle_inputs();
    endtask

    task automatic test_no_false_stall();
        logic [31:0] followers [3];
        $display("[TB] test_no_false_stall");
        followers[0] = itype(6'h08, 5'd7, 5'd6, 16'd1);
        followers[1] = itype(6'h2B, 5'd1, 5'd0, 16'd0);
        followers[2] = itype(6'h08, 5'd7, 5'd4, 16'd3);
        for (int i = 0; i < 3; i++) begin
            do_reset();
            if_valid = 1'b1;
            if_instr = itype(6'h23, 5'd1, 5'd4, 16'd8);
            tick();
            if_instr = followers[i];
            if_pc = 32'h200 + 32'(i);
            #1;
            checks++;
            if (if_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL no_stall_%0d got rdy=%b want 1", i, if_ready);
            end
            tick();
            checks++;
            if ({ex_valid, ex_pc} !== {1'b1, 32'h200 + 32'(i)}) begin
                errors++;
                $display("[TB] FAIL no_bubble_%0d got v=%b pc=%h want 1 %h", i, ex_valid, ex_pc, 32'h200 + 32'(i));
            end
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        $display("[TB] test_backpressure");
        do_reset();
        ex_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h100;
        if_instr = itype(6'h08, 5'd1, 5'd2, 16'd7);
        tick();
        if_pc = 32'h200;
        if_instr = itype(6'h08, 5'd3, 5'd5, 16'd9);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (if_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_ready_%0d got %b want 0", i, if_ready);
            end
            tick();
            checks++;
            if ({ex_valid, ex_pc, ex_rd, ex_imm} !== {1'b1, 32'h100, 5'd2, 32'd7}) begin
                errors++;
                $display("[TB] FAIL bp_hold_%0d got v=%b pc=%h rd=%0d want 1 100 2", i, ex_valid, ex_pc, ex_rd);
            end
        end
        ex_ready = 1'b1;
        #1;
        checks++;
        if (if_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release got %b want 1", if_ready);
        end
        tick();
        checks++;
        if ({ex_valid, ex_pc, ex_rd} !== {1'b1, 32'h200, 5'd5}) begin
            errors++;
            $display("[TB] FAIL bp_next got v=%b pc=%h rd=%0d want 1 200 5", ex_valid, ex_pc, ex_rd);
        end
        idle_inputs();
    endtask

    task automatic test_imm_dest();
        $display("[TB] test_imm_dest");
        do_reset();
        if_valid = 1'b1;
        if_instr = itype(6'h0D, 5'd0, 5'd2, 16'h8001);
        tick();
        checks++;
        if ({ex_imm, ex_rd, ex_we} !== {32'h00008001, 5'd2, 1'b1}) begin
            errors++;
            $display("[TB] FAIL ori_imm got imm=%h rd=%0d we=%b want 00008001 2 1", ex_imm, ex_rd, ex_we);
        end
        if_instr = itype(6'h08, 5'd0, 5'd2, 16'h8001);
        tick();
        checks++;
        if (ex_imm !== 32'hFFFF8001) begin
            errors++;
            $display("[TB] FAIL addi_imm got %h want ffff8001", ex_imm);
        end
        if_instr = itype(6'h08, 5'd1, 5'd0, 16'd5);
        tick();
        checks++;
        if ({ex_valid, ex_rd, ex_we} !== {1'b1, 5'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL r0_dest got v=%b rd=%0d we=%b want 1 0 0", ex_valid, ex_rd, ex_we);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_stall();
        $display("[TB] test_reset_mid_stall");
        do_reset();
        if_valid = 1'b1; rd1 = 32'h55;
        if_instr = itype(6'h23, 5'd1, 5'd4, 16'd8);
        tick();
        ex_ready = 1'b0;
        if_instr = rtype(5'd4, 5'd2, 5'd5, 6'h20);
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ex_valid, ex_op_a, if_ready} !== {1'b0, 32'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL mid_reset got v=%b a=%h rdy=%b want 0 0 1", ex_valid, ex_op_a, if_ready);
        end
        if_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({ex_valid, if_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL after_reset got v=%b rdy=%b want 0 1", ex_valid, if_ready);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [5:0] ops [10];
        logic       exp_ready;
        logic       stall;
        ex_t        got;
        $display("[TB] test_random");
        ops = '{6'h00, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0A};
        idle_inputs();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            if_instr = {ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        16'($urandom)};
            if (if_instr[31:26] == 6'h00 && $urandom_range(0, 1) == 1) if_instr[15:11] = 5'($urandom_range(0, 7));
            if_pc = $urandom;
            rd1 = $urandom; rd2 = $urandom;
            wb_we = $urandom_range(0, 1) == 1;
            wb_wa = 5'($urandom_range(0, 7));
            wb_wd = $urandom;
            #1;
            stall = model_stall(model, if_instr);
            exp_ready = (!model.valid || ex_ready) && !stall;
            checks++;
            if ({if_ready, ra1, ra2} !== {exp_ready, if_instr[25:21], if_instr[20:16]}) begin
                errors++;
                $display("[TB] FAIL rand_ready cyc %0d got rdy=%b ra1=%0d ra2=%0d want %b %0d %0d",
                         cyc, if_ready, ra1, ra2, exp_ready, if_instr[25:21], if_instr[20:16]);
            end
            if (!model.valid || ex_ready) begin
                if (if_valid && !stall) model = model_accept(if_instr, if_pc, rd1, rd2, wb_we, wb_wa, wb_wd);
                else model.valid = 1'b0;
            end
            tick();
            got = '{ex_valid, ex_pc, ex_op_a, ex_op_b, ex_imm, ex_opcode, ex_funct, ex_rd, ex_we, ex_is_load};
            checks++;
            if (got !== model) begin
                errors++;
                $display("[TB] FAIL rand_ex cyc %0d got v=%b pc=%h a=%h b=%h imm=%h rd=%0d we=%b ld=%b want v=%b pc=%h a=%h b=%h imm=%h rd=%0d we=%b ld=%b",
                         cyc, got.valid, got.pc, got.a, got.b, got.imm, got.rd, got.we, got.load,
                         model.valid, model.pc, model.a, model.b, model.imm, model.rd, model.we, model.load);
            end
        end
        idle_inputs();
    endtask

    initial begin
        model = '0;
        test_reset();
        test_bypass();
        test_load_use();
        test_no_false_stall();
        test_backpressure();
        test_imm_dest();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
